bcd_xs3_codec: RTL and testbench
================================

Name: bcd_xs3_codec

Overview:
Parametrised multi-digit converter between packed BCD and Excess-3 code, in both directions. Mode is selected per transaction. Digits are processed serially, one per clock, LSB digit first. A valid/ready handshake is used on both sides, and each digit gets an invalid-code flag. It sits on the decimal-datapath side of the design and replaces single-digit combinational BCD-to-Excess-3 conversion wherever multi-digit words, reverse decoding or flow control are needed.

Parameters:
NUM_DIGITS, 4, number of 4-bit decimal digits per word; legal range 1..16.
CNT_W, $clog2(NUM_DIGITS) (minimum 1), digit-index counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  input word present.
in_ready  output  1  block can accept a word.
in_mode  input  1  0 = BCD to Excess-3; 1 = Excess-3 to BCD; sampled on acceptance.
in_data  input  4*NUM_DIGITS  packed digits; digit i = bits [4i+3:4i].
out_valid  output  1  result word available.
out_ready  input  1  downstream accepts the result.
out_data  output  4*NUM_DIGITS  converted digits, same packing as in_data.
out_err  output  NUM_DIGITS  bit i set = input digit i was an invalid code.
out_any_err  output  1  OR-reduction of out_err.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, digit index = 0.
  - out_valid = 0, out_data = 0, out_err = 0, out_any_err = 0.
  - Captured data and mode registers = 0.
- Reset during CONV or DONE aborts the transaction immediately. The partial result is discarded and no out_valid is produced.
- FSM states: IDLE, CONV, DONE.
  - in_ready = (state == IDLE), decoded from the state register. in_ready is 1 while rst is held.
  - IDLE: on (in_valid && in_ready) at an edge, capture in_data and in_mode, set index = 0, clear out_err, go to CONV. in_data and in_mode are don't-care at all other times.
  - CONV: each edge converts captured digit[index] into out_data digit[index] and writes out_err[index].
    - If index < NUM_DIGITS-1: index increments.
    - If index == NUM_DIGITS-1: go to DONE.
  - DONE: out_valid = 1. out_data, out_err and out_any_err are held stable. in_valid is ignored.
    - On (out_valid && out_ready) at an edge: go to IDLE. out_valid = 0 and in_ready = 1 after that edge.
  - No bypass: a new word cannot be accepted on the same edge that a result is consumed.
- Latency: acceptance at edge E0; digit i is converted at edge E0+1+i; out_valid is visible after edge E0+NUM_DIGITS. Throughput is one word per NUM_DIGITS+2 cycles when out_ready is held high.
- Digit arithmetic (4-bit, no carry between digits):
  - Mode 0: valid if d <= 9; output d+3.
  - Mode 1: valid if 3 <= d <= 12; output d-3.
  - Invalid digit: output digit = 4'hF and the err bit is set. Conversion continues with the remaining digits; there is no abort.
- out_data digits not yet converted during CONV hold their previous value. Outputs are qualified only by out_valid.
- NUM_DIGITS = 1: CONV lasts exactly one cycle; the counter is unused but still present.

Test Plan:
1. N=4, mode 0, in_data 16'h1234 → out_data 16'h4567, out_err 4'b0000. out_valid rises 4 cycles after the acceptance edge.
2. N=4, mode 1, in_data 16'h3C4A → out_data 16'h0917, out_err 4'b0000, out_any_err 0.
3. N=4, invalid codes:
   - mode 0, 16'h9A05 → 16'hCF38, out_err 4'b0100.
   - mode 1, 16'h2D33 → 16'hFF00, out_err 4'b1100, out_any_err 1.
4. Backpressure: complete 16'h0009 in mode 0, hold out_ready = 0 for 5 cycles while in_valid = 1 with 16'h1111.
   - out_data stays 16'h333C and in_ready stays 0.
   - Raise out_ready: IDLE on the next edge; then 16'h1111 is accepted → 16'h4444.
5. Reset mid-operation: assert rst 2 cycles into CONV of 16'h5678.
   - out_valid = 0, out_data = 0, in_ready = 1 immediately.
   - After release, mode 0 with 16'h0000 → 16'h3333.
6. N=1 sweep, inputs 0..15 in both modes.
   - Mode 0: inputs 0..9 map to 3..12; 10..15 give F with err = 1.
   - Mode 1: inputs 3..12 map to 0..9; other inputs give F with err = 1.
   - Every result arrives 1 cycle after acceptance.

Source files
------------

// File: rtl/bcd_xs3_codec.sv
// Multi-digit BCD <-> Excess-3 converter with a valid/ready handshake on both sides.
// Digits are converted serially, one per clock, starting with the least significant digit.
module bcd_xs3_codec #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_any_err
);

  localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   data_q, data_d;
  logic                      mode_q, mode_d;
  logic [4*NUM_DIGITS-1:0]   out_data_q, out_data_d;
  logic [NUM_DIGITS-1:0]     out_err_q, out_err_d;

  logic [3:0]                cur_digit;
  logic [3:0]                conv_digit;
  logic                      conv_err;

  // Select the captured digit addressed by the serial index.
  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == CNT_W'(i)) begin
        cur_digit = data_q[4*i +: 4];
      end
    end
  end

  // Per-digit arithmetic; invalid codes yield 4'hF and raise the error flag.
  always_comb begin
    conv_digit = 4'hF;
    conv_err   = 1'b1;
    if (!mode_q) begin
      if (cur_digit <= 4'd9) begin
        conv_digit = cur_digit + 4'd3;
        conv_err   = 1'b0;
      end
    end else begin
      if ((cur_digit >= 4'd3) && (cur_digit <= 4'd12)) begin
        conv_digit = cur_digit - 4'd3;
        conv_err   = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d    = in_data;
          mode_d    = in_mode;
          idx_d     = '0;
          out_err_d = '0;
          state_d   = StConv;
        end
      end
      StConv: begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (idx_q == CNT_W'(i)) begin
            out_data_d[4*i +: 4] = conv_digit;
            out_err_d[i]         = conv_err;
          end
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;
  assign out_any_err = |out_err_q;

endmodule

// File: tb/tb_bcd_xs3_codec.sv
// Directed bench for bcd_xs3_codec: a 4-digit instance for the main vectors and
// a 1-digit instance for the exhaustive single-digit sweep.
module tb_bcd_xs3_codec;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_any_err;
  logic [15:0] in_data, out_data;
  logic [3:0]  out_err;

  logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_any_err;
  logic [3:0]  s_in_data, s_out_data;
  logic [0:0]  s_out_err;

  int checks;
  int failures;

  logic [63:0] exp0_tbl, exp1_tbl;
  logic [15:0] err0_tbl, err1_tbl;

  bcd_xs3_codec #(.NUM_DIGITS(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_any_err(out_any_err)
  );

  bcd_xs3_codec #(.NUM_DIGITS(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_mode    (s_in_mode),
    .in_data    (s_in_data),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_data   (s_out_data),
    .out_err    (s_out_err),
    .out_any_err(s_out_any_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic start4(input logic m, input logic [15:0] d);
    @(negedge clk);
    check("in_ready_before_start", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 1'($urandom);
  endtask

  task automatic wait4(input string tag, input logic [15:0] ed, input logic [3:0] ee);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    check({tag, "_data"}, {48'd0, out_data}, {48'd0, ed});
    check({tag, "_err"}, {60'd0, out_err}, {60'd0, ee});
    check({tag, "_any_err"}, {63'd0, out_any_err}, {63'd0, (ee != 4'd0)});
  endtask

  task automatic consume4(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run1(input logic m, input logic [3:0] d, input logic [3:0] ed, input logic ee);
    int cyc = 0;
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_mode  = m;
    s_in_data  = d;
    @(negedge clk);
    s_in_valid = 1'b0;
    while (!s_out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("n1_m%0d_d%0d_latency", m, d), 64'(cyc), 64'd1);
    check($sformatf("n1_m%0d_d%0d_data", m, d), {60'd0, s_out_data}, {60'd0, ed});
    check($sformatf("n1_m%0d_d%0d_err", m, d), {63'd0, s_out_err}, {63'd0, ee});
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_mode     = 1'b0;
    in_data     = 16'h0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_in_mode   = 1'b0;
    s_in_data   = 4'h0;
    s_out_ready = 1'b0;
    // Expected single-digit results, nibble i = result for input i.
    exp0_tbl = 64'hFFFF_FFCB_A987_6543;
    exp1_tbl = 64'hFFF9_8765_4321_0FFF;
    err0_tbl = 16'hFC00;
    err1_tbl = 16'hE007;

    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {48'd0, out_data}, 64'd0);
    check("rst_out_err", {60'd0, out_err}, 64'd0);
    check("rst_any_err", {63'd0, out_any_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    start4(1'b0, 16'h1234);
    wait4("m0_1234", 16'h4567, 4'b0000);
    consume4("m0_1234");

    start4(1'b1, 16'h3C4A);
    wait4("m1_3c4a", 16'h0917, 4'b0000);
    consume4("m1_3c4a");

    start4(1'b0, 16'h9A05);
    wait4("m0_9a05", 16'hCF38, 4'b0100);
    consume4("m0_9a05");

    start4(1'b1, 16'h2D33);
    wait4("m1_2d33", 16'hFF00, 4'b1100);
    consume4("m1_2d33");

    // Backpressure with a pending word held on the input.
    start4(1'b0, 16'h0009);
    wait4("bp_0009", 16'h333C, 4'b0000);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_data", i), {48'd0, out_data}, 64'h333C);
      check($sformatf("bp_hold%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("bp_hold%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait4("bp_1111", 16'h4444, 4'b0000);
    consume4("bp_1111");

    // Reset two cycles into conversion.
    start4(1'b0, 16'h5678);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", {48'd0, out_data}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_err", {60'd0, out_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("postrst%0d_out_valid", i), {63'd0, out_valid}, 64'd0);
    end
    start4(1'b0, 16'h0000);
    wait4("m0_0000", 16'h3333, 4'b0000);
    consume4("m0_0000");

    // Single-digit sweep over all codes in both modes.
    for (int d = 0; d < 16; d++) begin
      run1(1'b0, 4'(d), exp0_tbl[4*d +: 4], err0_tbl[d]);
    end
    for (int d = 0; d < 16; d++) begin
      run1(1'b1, 4'(d), exp1_tbl[4*d +: 4], err1_tbl[d]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
